// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants, address type and requester index for the
//               register-file writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0] reg_addr_t;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_idx_e;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. A lone request always wins; on
//               contention the requester not granted last wins. The
//               last-granted record only moves when something is granted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_idx_e rr_last_q;
    req_idx_e rr_last_d;

    // Grant selection and next last-granted record
    always_comb begin
        gnt       = 2'b00;
        rr_last_d = rr_last_q;
        if (req == 2'b11) begin
            gnt = (rr_last_q == REQ_LSU) ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
        if (gnt[1]) begin
            rr_last_d = REQ_LSU;
        end else if (gnt[0]) begin
            rr_last_d = REQ_ALU;
        end
    end

    // Last-granted flop; reset favours the ALU on the first contention
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= REQ_LSU;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register file write port between the ALU and the
//               load unit, registers the winner onto the write port and keeps
//               a pending-write scoreboard for decode RAW hazard checks.
//               Optional macro REGFILE_WB_FWD_EN adds writeback-cycle
//               forwarding outputs so busy drops one cycle earlier.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic            pll_1_200MHz,
    input  logic            rst,
    input  logic            iss_valid,
    input  reg_addr_t       iss_rd,
    output logic            iss_ready,
    input  logic            req0_valid,
    input  reg_addr_t       req0_rd,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  reg_addr_t       req1_rd,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    output logic            wb_we,
    output reg_addr_t       wb_rd,
    output logic [XLEN-1:0] wb_data,
    input  reg_addr_t       rs1,
    input  reg_addr_t       rs2,
`ifdef REGFILE_WB_FWD_EN
    output logic            rs1_fwd,
    output logic            rs2_fwd,
    output logic [XLEN-1:0] rs1_fwd_data,
    output logic [XLEN-1:0] rs2_fwd_data,
`endif
    output logic            rs1_busy,
    output logic            rs2_busy
);

    logic [1:0]      w_gnt;
    logic            w_any_gnt;
    reg_addr_t       w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic            w_iss_fire;

    logic            wb_we_q,   wb_we_d;
    reg_addr_t       wb_rd_q,   wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [NREG-1:0] pending_q, pending_d;

    rr_arb2 u_arb (
        .clk (pll_1_200MHz),
        .rst (rst),
        .req ({req1_valid, req0_valid}),
        .gnt (w_gnt)
    );

    assign req0_ready = w_gnt[REQ_ALU];
    assign req1_ready = w_gnt[REQ_LSU];
    assign w_any_gnt  = |w_gnt;

    // Winner mux and next write-port values; x0 writes are consumed silently
    always_comb begin
        w_sel_rd   = w_gnt[REQ_LSU] ? req1_rd   : req0_rd;
        w_sel_data = w_gnt[REQ_LSU] ? req1_data : req0_data;
        wb_we_d    = w_any_gnt && (w_sel_rd != '0);
        wb_rd_d    = w_any_gnt ? w_sel_rd   : wb_rd_q;
        wb_data_d  = w_any_gnt ? w_sel_data : wb_data_q;
    end

    assign iss_ready  = ~pending_q[iss_rd];
    assign w_iss_fire = iss_valid & iss_ready;

    // Scoreboard update: writeback clears, issue sets (set wins), x0 never pending
    always_comb begin
        pending_d = pending_q;
        if (wb_we_q) begin
            pending_d[wb_rd_q] = 1'b0;
        end
        if (w_iss_fire) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Write-port register and scoreboard state
    always_ff @(posedge pll_1_200MHz or posedge rst) begin
        if (rst) begin
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            pending_q <= '0;
        end else begin
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            pending_q <= pending_d;
        end
    end

    assign wb_we   = wb_we_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;

`ifdef REGFILE_WB_FWD_EN
    // A write landing this cycle can be bypassed, so the reader need not stall
    assign rs1_fwd      = wb_we_q && (wb_rd_q == rs1) && (rs1 != '0);
    assign rs2_fwd      = wb_we_q && (wb_rd_q == rs2) && (rs2 != '0);
    assign rs1_fwd_data = wb_data_q;
    assign rs2_fwd_data = wb_data_q;
    assign rs1_busy     = pending_q[rs1] & ~rs1_fwd;
    assign rs2_busy     = pending_q[rs2] & ~rs2_fwd;
`else
    assign rs1_busy     = pending_q[rs1];
    assign rs2_busy     = pending_q[rs2];
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter. Expected write-port
//               transactions are queued at grant time and compared by a
//               separate monitor whenever wb_we is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic        req0_valid;
    logic [4:0]  req0_rd;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_rd;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
`ifdef REGFILE_WB_FWD_EN
    logic        rs1_fwd;
    logic        rs2_fwd;
    logic [31:0] rs1_fwd_data;
    logic [31:0] rs2_fwd_data;
`endif

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    wb_exp_t mon_e;
    int      n_checks = 0;
    int      n_errors = 0;

    regfile_wb_arbiter dut (
        .pll_1_200MHz (clk),
        .rst          (rst),
        .iss_valid    (iss_valid),
        .iss_rd       (iss_rd),
        .iss_ready    (iss_ready),
        .req0_valid   (req0_valid),
        .req0_rd      (req0_rd),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_rd      (req1_rd),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .rs1          (rs1),
        .rs2          (rs2),
`ifdef REGFILE_WB_FWD_EN
        .rs1_fwd      (rs1_fwd),
        .rs2_fwd      (rs2_fwd),
        .rs1_fwd_data (rs1_fwd_data),
        .rs2_fwd_data (rs2_fwd_data),
`endif
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    // Monitor: every presented write must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && wb_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL wb_unexpected: got rd=%0d data=0x%0h expected no write at %0t",
                         wb_rd, wb_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (wb_rd !== mon_e.rd || wb_data !== mon_e.data) begin
                    n_errors++;
                    $display("FAIL wb_port: got rd=%0d data=0x%0h expected rd=%0d data=0x%0h at %0t",
                             wb_rd, wb_data, mon_e.rd, mon_e.data, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        iss_valid  = 1'b0;
        iss_rd     = '0;
        req0_valid = 1'b0;
        req0_rd    = '0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_rd    = '0;
        req1_data  = '0;
        rs1        = '0;
        rs2        = '0;

        // Reset state
        #12;
        iss_rd = 5'd3;
        rs1    = 5'd3;
        #1;
        chk("reset_wb_we", {31'd0, wb_we}, 32'd0);
        chk("reset_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_iss_ready", {31'd0, iss_ready}, 32'd1);
        chk("reset_rs1_busy", {31'd0, rs1_busy}, 32'd0);
        rst = 1'b0;
        cyc();

        // Reset mid-stream: pending = 0xF0 and a write on the port
        for (int i = 4; i < 8; i++) begin
            iss_valid = 1'b1;
            iss_rd    = 5'(i);
            #1;
            chk("t1_iss_ready", {31'd0, iss_ready}, 32'd1);
            cyc();
        end
        iss_valid = 1'b0;
        rs1 = 5'd7;
        #1;
        chk("t1_rs1_busy_x7", {31'd0, rs1_busy}, 32'd1);
        req0_valid = 1'b1;
        req0_rd    = 5'd4;
        req0_data  = 32'h0000_AAAA;
        #1;
        chk("t1_req0_ready", {31'd0, req0_ready}, 32'd1);
        exp_q.push_back('{rd: 5'd4, data: 32'h0000_AAAA});
        cyc();
        req0_valid = 1'b0;
        chk("t1_wb_we_before_rst", {31'd0, wb_we}, 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        iss_rd = 5'd5;
        #1;
        chk("t1_async_wb_we", {31'd0, wb_we}, 32'd0);
        chk("t1_async_rs1_busy", {31'd0, rs1_busy}, 32'd0);
        chk("t1_async_iss_ready", {31'd0, iss_ready}, 32'd1);
        cyc();
        rst = 1'b0;
        cyc();

        // Single ALU request, one-cycle latency
        req0_valid = 1'b1;
        req0_rd    = 5'd5;
        req0_data  = 32'hDEAD_BEEF;
        #1;
        chk("t2_req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("t2_req1_ready", {31'd0, req1_ready}, 32'd0);
        exp_q.push_back('{rd: 5'd5, data: 32'hDEAD_BEEF});
        cyc();
        req0_valid = 1'b0;
        #1;
        chk("t2_wb_we_n1", {31'd0, wb_we}, 32'd1);
        chk("t2_wb_rd_n1", {27'd0, wb_rd}, 32'd5);
        chk("t2_wb_data_n1", wb_data, 32'hDEAD_BEEF);
        cyc();
        chk("t2_wb_we_n2", {31'd0, wb_we}, 32'd0);

        // Continuous contention right after reset: 0,1,0,1
        do_reset();
        req0_valid = 1'b1;
        req0_rd    = 5'd3;
        req0_data  = 32'h0000_0300;
        req1_valid = 1'b1;
        req1_rd    = 5'd4;
        req1_data  = 32'h0000_0400;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_req0_ready", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_req1_ready", {31'd0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            if (i % 2 == 0) exp_q.push_back('{rd: 5'd3, data: 32'h0000_0300});
            else            exp_q.push_back('{rd: 5'd4, data: 32'h0000_0400});
            cyc();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc();

        // Double issue of x7 stalls until its writeback
        iss_valid = 1'b1;
        iss_rd    = 5'd7;
        rs1       = 5'd7;
        #1;
        chk("t4_first_iss_ready", {31'd0, iss_ready}, 32'd1);
        cyc();
        chk("t4_second_iss_ready", {31'd0, iss_ready}, 32'd0);
        chk("t4_rs1_busy", {31'd0, rs1_busy}, 32'd1);
        req1_valid = 1'b1;
        req1_rd    = 5'd7;
        req1_data  = 32'h0000_0077;
        #1;
        chk("t4_req1_ready", {31'd0, req1_ready}, 32'd1);
        exp_q.push_back('{rd: 5'd7, data: 32'h0000_0077});
        cyc();
        req1_valid = 1'b0;
        chk("t4_iss_ready_wb_cycle", {31'd0, iss_ready}, 32'd0);
        cyc();
        chk("t4_iss_ready_after_wb", {31'd0, iss_ready}, 32'd1);
        chk("t4_rs1_busy_after_wb", {31'd0, rs1_busy}, 32'd0);
        cyc();
        iss_valid = 1'b0;
        chk("t4_rs1_busy_reissued", {31'd0, rs1_busy}, 32'd1);
        req0_valid = 1'b1;
        req0_rd    = 5'd7;
        req0_data  = 32'h0000_7700;
        exp_q.push_back('{rd: 5'd7, data: 32'h0000_7700});
        cyc();
        req0_valid = 1'b0;
        cyc();
        chk("t4_rs1_busy_cleared", {31'd0, rs1_busy}, 32'd0);

        // x0: consumed without a write, never pending
        req1_valid = 1'b1;
        req1_rd    = 5'd0;
        req1_data  = 32'h0000_1234;
        #1;
        chk("t5_req1_ready_x0", {31'd0, req1_ready}, 32'd1);
        cyc();
        req1_valid = 1'b0;
        chk("t5_wb_we_x0", {31'd0, wb_we}, 32'd0);
        iss_valid = 1'b1;
        iss_rd    = 5'd0;
        rs1       = 5'd0;
        #1;
        chk("t5_iss_ready_x0", {31'd0, iss_ready}, 32'd1);
        cyc();
        iss_valid = 1'b0;
        chk("t5_iss_ready_x0_after", {31'd0, iss_ready}, 32'd1);
        chk("t5_rs1_busy_x0", {31'd0, rs1_busy}, 32'd0);

        // Writeback cycle of a pending register seen by rs2
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        rs2       = 5'd9;
        cyc();
        iss_valid = 1'b0;
        chk("t6_rs2_busy_pending", {31'd0, rs2_busy}, 32'd1);
        req0_valid = 1'b1;
        req0_rd    = 5'd9;
        req0_data  = 32'h0000_0055;
        exp_q.push_back('{rd: 5'd9, data: 32'h0000_0055});
        cyc();
        req0_valid = 1'b0;
`ifdef REGFILE_WB_FWD_EN
        chk("t6_rs2_fwd", {31'd0, rs2_fwd}, 32'd1);
        chk("t6_rs2_fwd_data", rs2_fwd_data, 32'h0000_0055);
        chk("t6_rs2_busy_wb_cycle", {31'd0, rs2_busy}, 32'd0);
`else
        chk("t6_rs2_busy_wb_cycle", {31'd0, rs2_busy}, 32'd1);
`endif
        cyc();
        chk("t6_rs2_busy_after", {31'd0, rs2_busy}, 32'd0);

        // Drain and confirm every expected write was seen
        cyc();
        cyc();
        chk("drain_expected_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
